inst_fifo: RTL and testbench

//  Fetch-to-decode instruction queue ahead of the dual (alpha/beta) decode stage.

---
 rtl/inst_fifo_if.sv | 36 +++
 rtl/inst_fifo.sv | 106 ++++++++++
 tb/tb_inst_fifo.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fifo_if.sv
// Fetch/decode side bundle of the instruction queue.
// Address-error read flags exist only when INST_FIFO_ADDR_ERR_EN is defined.
interface inst_fifo_if;
    logic        write_en1, write_en2;
    logic [31:0] write_inst1, write_inst2;
    logic [31:0] write_pc1, write_pc2;
    logic        full;
    logic        read_en1, read_en2;
    logic        read_valid1, read_valid2;
    logic [31:0] read_inst1, read_inst2;
    logic [31:0] read_pc1, read_pc2;
    logic        empty;
`ifdef INST_FIFO_ADDR_ERR_EN
    logic        read_addr_err1, read_addr_err2;
`endif

    modport master (
        output write_en1, write_en2, write_inst1, write_inst2, write_pc1, write_pc2,
        output read_en1, read_en2,
`ifdef INST_FIFO_ADDR_ERR_EN
        input  read_addr_err1, read_addr_err2,
`endif
        input  full, empty, read_valid1, read_valid2,
        input  read_inst1, read_inst2, read_pc1, read_pc2
    );

    modport slave (
        input  write_en1, write_en2, write_inst1, write_inst2, write_pc1, write_pc2,
        input  read_en1, read_en2,
`ifdef INST_FIFO_ADDR_ERR_EN
        output read_addr_err1, read_addr_err2,
`endif
        output full, empty, read_valid1, read_valid2,
        output read_inst1, read_inst2, read_pc1, read_pc2
    );
endinterface

// File: rtl/inst_fifo.sv
// Dual-issue fetch-to-decode instruction queue: 2 pushes / 2 pops per cycle, flushable.
// Optional INST_FIFO_ADDR_ERR_EN adds a per-entry misaligned-PC flag on each read port.
module inst_fifo_rd_lane #(
    parameter int DEPTH = 16,
    parameter int EW    = 64,
    parameter int LANE  = 0
) (
    input  logic [DEPTH-1:0][EW-1:0]     mem,
    input  logic [$clog2(DEPTH)-1:0]     rd_ptr,
    input  logic [$clog2(DEPTH):0]       count,
    output logic                         valid,
    output logic [EW-1:0]                entry
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] idx;

    // Index wraps naturally at the pointer width.
    assign idx   = rd_ptr + PW'(LANE);
    assign valid = count > CW'(LANE);
    assign entry = mem[idx];
endmodule

module inst_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    inst_fifo_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
`ifdef INST_FIFO_ADDR_ERR_EN
    localparam int EW = 65;
`else
    localparam int EW = 64;
`endif

    logic [DEPTH-1:0][EW-1:0] mem;
    logic [PW-1:0]            wr_ptr, rd_ptr;
    logic [CW-1:0]            count;
    logic                     full;
    logic [1:0]               push_n, pop_req, pop_n;
    logic [1:0][EW-1:0]       wr_entry, rd_entry;
    logic [1:0]               rd_valid;

    // Entry layout: {[addr_err], pc, inst}
`ifdef INST_FIFO_ADDR_ERR_EN
    assign wr_entry[0] = {bus.write_pc1[1:0] != 2'b00, bus.write_pc1, bus.write_inst1};
    assign wr_entry[1] = {bus.write_pc2[1:0] != 2'b00, bus.write_pc2, bus.write_inst2};
`else
    assign wr_entry[0] = {bus.write_pc1, bus.write_inst1};
    assign wr_entry[1] = {bus.write_pc2, bus.write_inst2};
`endif

    // Fewer than two free slots blocks the whole push, so fetch never splits a pair.
    assign full    = count >= CW'(DEPTH - 1);
    assign push_n  = full ? 2'd0
                          : 2'(bus.write_en1) + 2'(bus.write_en1 & bus.write_en2);
    assign pop_req = 2'(bus.read_en1) + 2'(bus.read_en1 & bus.read_en2);
    assign pop_n   = (CW'(pop_req) > count) ? count[1:0] : pop_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            for (int k = 0; k < 2; k++)
                if (push_n > 2'(k)) mem[wr_ptr + PW'(k)] <= wr_entry[k];
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop_n);
            count  <= count + CW'(push_n) - CW'(pop_n);
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_lane
        inst_fifo_rd_lane #(.DEPTH(DEPTH), .EW(EW), .LANE(g)) u_lane (
            .mem    (mem),
            .rd_ptr (rd_ptr),
            .count  (count),
            .valid  (rd_valid[g]),
            .entry  (rd_entry[g])
        );
    end

    assign bus.full        = full;
    assign bus.empty       = count == '0;
    assign bus.read_valid1 = rd_valid[0];
    assign bus.read_valid2 = rd_valid[1];
    assign bus.read_inst1  = rd_entry[0][31:0];
    assign bus.read_inst2  = rd_entry[1][31:0];
    assign bus.read_pc1    = rd_entry[0][63:32];
    assign bus.read_pc2    = rd_entry[1][63:32];
`ifdef INST_FIFO_ADDR_ERR_EN
    assign bus.read_addr_err1 = rd_entry[0][64] & rd_valid[0];
    assign bus.read_addr_err2 = rd_entry[1][64] & rd_valid[1];
`endif
endmodule

// File: tb/tb_inst_fifo.sv
// Directed-vector bench for inst_fifo (DEPTH=16); covers reset, pairing, full, wrap, flush.
module tb_inst_fifo;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   vectors = 0;
    int   miscompares = 0;

    inst_fifo_if bus();

    inst_fifo #(.DEPTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.write_en1 = 1'b0; bus.write_en2 = 1'b0;
        bus.read_en1  = 1'b0; bus.read_en2  = 1'b0;
        flush = 1'b0;
    endtask

    task automatic set_push(input logic e1, input logic e2,
                            input logic [31:0] i1, input logic [31:0] p1,
                            input logic [31:0] i2, input logic [31:0] p2);
        bus.write_en1 = e1; bus.write_en2 = e2;
        bus.write_inst1 = i1; bus.write_pc1 = p1;
        bus.write_inst2 = i2; bus.write_pc2 = p2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        set_push(1'b0, 1'b0, '0, '0, '0, '0);
        step(); step(); step();
        rst = 1'b0;
        // traffic, then reset again in the middle of a push
        set_push(1'b1, 1'b1, 32'h1111_1111, 32'h0000_0100, 32'h2222_2222, 32'h0000_0104);
        step();
        rst = 1'b1;
        step(); step(); step();
        vectors++;
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty got %b want 1", bus.empty); end
        vectors++;
        if (bus.full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", bus.full); end
        vectors++;
        if ({bus.read_valid1, bus.read_valid2} !== 2'b00) begin
            miscompares++; $display("FAIL reset_valid got %b%b want 00", bus.read_valid1, bus.read_valid2);
        end
        vectors++;
        if (bus.read_inst1 !== 32'h0 || bus.read_pc1 !== 32'h0) begin
            miscompares++; $display("FAIL reset_data got %h@%h want 0@0", bus.read_inst1, bus.read_pc1);
        end
        rst = 1'b0;
        idle();
        step();
    endtask

    task automatic test_pair();
        set_push(1'b1, 1'b1, 32'h2401_0001, 32'hBFC0_0000, 32'h2402_0002, 32'hBFC0_0004);
        step();
        idle();
        vectors++;
        if ({bus.read_valid1, bus.read_valid2} !== 2'b11) begin
            miscompares++; $display("FAIL pair_valid got %b%b want 11", bus.read_valid1, bus.read_valid2);
        end
        vectors++;
        if (bus.read_inst1 !== 32'h2401_0001 || bus.read_pc1 !== 32'hBFC0_0000) begin
            miscompares++; $display("FAIL pair_port1 got %h@%h want 24010001@bfc00000", bus.read_inst1, bus.read_pc1);
        end
        vectors++;
        if (bus.read_inst2 !== 32'h2402_0002 || bus.read_pc2 !== 32'hBFC0_0004) begin
            miscompares++; $display("FAIL pair_port2 got %h@%h want 24020002@bfc00004", bus.read_inst2, bus.read_pc2);
        end
        bus.read_en1 = 1'b1; bus.read_en2 = 1'b1;
        step();
        idle();
        vectors++;
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL pair_drain got empty=%b want 1", bus.empty); end
    endtask

    // Free entries < 2 means full only at count >= 15; eight pairs fill all 16 slots.
    task automatic test_full();
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus.full !== 1'b0) begin miscompares++; $display("FAIL full_early pair %0d got %b want 0", k, bus.full); end
            set_push(1'b1, 1'b1, 32'h1000_0000 + 2*k, 32'h8000_0000 + 8*k,
                     32'h1000_0001 + 2*k, 32'h8000_0004 + 8*k);
            step();
        end
        vectors++;
        if (bus.full !== 1'b1) begin miscompares++; $display("FAIL full_set got %b want 1", bus.full); end
        set_push(1'b1, 1'b1, 32'hDEAD_0000, 32'h0, 32'hDEAD_0001, 32'h4);
        step();
        idle();
        vectors++;
        if (bus.full !== 1'b1 || bus.read_inst1 !== 32'h1000_0000) begin
            miscompares++; $display("FAIL full_drop got full=%b head=%h want 1/10000000", bus.full, bus.read_inst1);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (bus.read_inst1 !== 32'h1000_0000 + 2*k || bus.read_inst2 !== 32'h1000_0001 + 2*k ||
                bus.read_pc1 !== 32'h8000_0000 + 8*k || bus.read_pc2 !== 32'h8000_0004 + 8*k) begin
                miscompares++;
                $display("FAIL full_order pair %0d got %h@%h %h@%h want %h %h", k, bus.read_inst1, bus.read_pc1,
                         bus.read_inst2, bus.read_pc2, 32'h1000_0000 + 2*k, 32'h1000_0001 + 2*k);
            end
            bus.read_en1 = 1'b1; bus.read_en2 = 1'b1;
            step();
        end
        idle();
        vectors++;
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL full_drain got empty=%b want 1", bus.empty); end
    endtask

    task automatic test_back_to_back();
        set_push(1'b1, 1'b1, 32'h3000_0000, 32'h4000_0000, 32'h3000_0001, 32'h4000_0004);
        step();
        for (int c = 0; c < 20; c++) begin
            vectors++;
            if ({bus.read_valid1, bus.read_valid2} !== 2'b11 ||
                bus.read_inst1 !== 32'h3000_0000 + 2*c || bus.read_inst2 !== 32'h3000_0001 + 2*c ||
                bus.read_pc1 !== 32'h4000_0000 + 8*c || bus.read_pc2 !== 32'h4000_0004 + 8*c) begin
                miscompares++;
                $display("FAIL stream cycle %0d got v=%b%b %h %h want 11 %h %h", c, bus.read_valid1,
                         bus.read_valid2, bus.read_inst1, bus.read_inst2, 32'h3000_0000 + 2*c, 32'h3000_0001 + 2*c);
            end
            set_push(1'b1, 1'b1, 32'h3000_0002 + 2*c, 32'h4000_0008 + 8*c,
                     32'h3000_0003 + 2*c, 32'h4000_000C + 8*c);
            bus.read_en1 = 1'b1; bus.read_en2 = 1'b1;
            step();
        end
        idle();
        vectors++;
        if (bus.read_inst1 !== 32'h3000_0028 || bus.read_inst2 !== 32'h3000_0029) begin
            miscompares++; $display("FAIL stream_tail got %h %h want 30000028 30000029", bus.read_inst1, bus.read_inst2);
        end
        bus.read_en1 = 1'b1; bus.read_en2 = 1'b1;
        step();
        idle();
        vectors++;
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL stream_drain got empty=%b want 1", bus.empty); end
    endtask

    task automatic test_edge();
        set_push(1'b1, 1'b0, 32'h5000_0001, 32'h0000_2000, 32'h5000_0002, 32'h0000_2004);
        step();
        idle();
        vectors++;
        if ({bus.read_valid1, bus.read_valid2} !== 2'b10 || bus.read_inst1 !== 32'h5000_0001) begin
            miscompares++; $display("FAIL single_push got v=%b%b %h want 10 50000001", bus.read_valid1,
                                    bus.read_valid2, bus.read_inst1);
        end
        bus.read_en1 = 1'b1; bus.read_en2 = 1'b1;
        step();
        idle();
        vectors++;
        if (bus.empty !== 1'b1 || bus.read_valid1 !== 1'b0) begin
            miscompares++; $display("FAIL over_pop got empty=%b v1=%b want 1 0", bus.empty, bus.read_valid1);
        end
        set_push(1'b0, 1'b1, 32'h5000_0003, 32'h0, 32'h5000_0004, 32'h4);
        step();
        idle();
        vectors++;
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL we2_only got empty=%b want 1", bus.empty); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) begin
            set_push(1'b1, 1'b1, 32'h6000_0000 + 2*k, 32'h0, 32'h6000_0001 + 2*k, 32'h4);
            step();
        end
        set_push(1'b1, 1'b1, 32'h6000_00AA, 32'h0, 32'h6000_00BB, 32'h4);
        bus.read_en1 = 1'b1; bus.read_en2 = 1'b1;
        flush = 1'b1;
        step();
        idle();
        vectors++;
        if (bus.empty !== 1'b1 || {bus.read_valid1, bus.read_valid2} !== 2'b00) begin
            miscompares++; $display("FAIL flush_clear got empty=%b v=%b%b want 1 00", bus.empty,
                                    bus.read_valid1, bus.read_valid2);
        end
        set_push(1'b1, 1'b0, 32'hCAFE_0001, 32'h0000_1234, 32'h0, 32'h0);
        step();
        idle();
        vectors++;
        if ({bus.read_valid1, bus.read_valid2} !== 2'b10 || bus.read_inst1 !== 32'hCAFE_0001 ||
            bus.read_pc1 !== 32'h0000_1234) begin
            miscompares++; $display("FAIL flush_refill got v=%b%b %h@%h want 10 cafe0001@00001234",
                                    bus.read_valid1, bus.read_valid2, bus.read_inst1, bus.read_pc1);
        end
        bus.read_en1 = 1'b1;
        step();
        idle();
    endtask

    task automatic test_addr_err();
        set_push(1'b1, 1'b1, 32'h7000_0001, 32'hBFC0_0002, 32'h7000_0002, 32'hBFC0_0008);
        step();
        idle();
        vectors++;
        if (bus.read_pc1 !== 32'hBFC0_0002 || bus.read_pc2 !== 32'hBFC0_0008) begin
            miscompares++; $display("FAIL misaligned_pc got %h %h want bfc00002 bfc00008", bus.read_pc1, bus.read_pc2);
        end
`ifdef INST_FIFO_ADDR_ERR_EN
        vectors++;
        if ({bus.read_addr_err1, bus.read_addr_err2} !== 2'b10) begin
            miscompares++; $display("FAIL addr_err got %b%b want 10", bus.read_addr_err1, bus.read_addr_err2);
        end
`endif
        bus.read_en1 = 1'b1;
        step();
        idle();
`ifdef INST_FIFO_ADDR_ERR_EN
        vectors++;
        if ({bus.read_addr_err1, bus.read_addr_err2} !== 2'b00) begin
            miscompares++; $display("FAIL addr_err_after got %b%b want 00", bus.read_addr_err1, bus.read_addr_err2);
        end
`endif
        bus.read_en1 = 1'b1;
        step();
        idle();
        vectors++;
        if (bus.empty !== 1'b1) begin miscompares++; $display("FAIL addr_err_drain got empty=%b want 1", bus.empty); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_full();
        test_back_to_back();
        test_edge();
        test_flush();
        test_addr_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want completion");
        $fatal(1);
    end
endmodule
